// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 binary multiplier.
//   Iterative radix-2^RADIX_BITS significand multiply. Five rounding modes
//   with exact subnormal handling. Exception flags. Valid/ready on both sides.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  operand handshake; a, b and rnd are captured on transfer
//   a, b                 operands {sign, exponent[NEXP], fraction[NSIG]}
//   rnd                  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE
//   out_valid/out_ready  result handshake; p, pFlags and exc are held until taken
//   p                    product
//   pFlags               one-hot class {SNAN, QNAN, INFINITY, ZERO, SUBNORMAL, NORMAL}
//   exc                  {invalid, overflow, underflow, inexact}
//
// state | meaning
// IDLE  | ready for operands; specials are resolved here and go straight to DONE
// NORM  | left-justify subnormal significands, A first, then B
// MUL   | shift-add, RADIX_BITS multiplier bits per cycle, MSB digit first
// RND   | normalise, denormalise if tiny, round, register the result
// DONE  | result presented until out_ready
module fp_mul_seq #(
  parameter int NEXP       = 8,
  parameter int NSIG       = 23,
  parameter int RADIX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NEXP+NSIG:0] a,
  input  logic [NEXP+NSIG:0] b,
  input  logic [2:0]         rnd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NEXP+NSIG:0] p,
  output logic [5:0]         pFlags,
  output logic [3:0]         exc
);
  localparam int W      = NEXP + NSIG + 1;
  localparam int SW     = NSIG + 1;
  localparam int PW     = 2 * SW;
  localparam int NITER  = (SW + RADIX_BITS - 1) / RADIX_BITS;
  localparam int MW     = NITER * RADIX_BITS;
  localparam int CW     = $clog2(NITER + 1);
  // Working exponent is two's complement with headroom for two fully
  // normalised subnormals minus the bias.
  localparam int EW     = NEXP + $clog2(NSIG + 1) + 3;
  localparam int BIAS   = (1 << (NEXP - 1)) - 1;
  localparam int EMAXF  = (1 << NEXP) - 1;

  localparam int F_SNAN = 5;
  localparam int F_QNAN = 4;
  localparam int F_INF  = 3;
  localparam int F_ZERO = 2;
  localparam int F_SUB  = 1;
  localparam int F_NORM = 0;

  typedef enum logic [2:0] {IDLE, NORM, MUL, RND, DONE} state_t;

  state_t         state;
  logic [2:0]     rnd_q;
  logic           sign_q;
  logic [SW-1:0]  sig_a;
  logic [MW-1:0]  mplier;
  logic [EW-1:0]  exp_a, exp_b;
  logic [PW-1:0]  acc;
  logic [CW-1:0]  cnt;

  // operand classification
  logic [NEXP-1:0] ea_f, eb_f;
  logic [NSIG-1:0] fa, fb;
  logic a_nan, a_snan, a_inf, a_zero, a_sub;
  logic b_nan, b_snan, b_inf, b_zero, b_sub;
  logic s_sign;

  assign ea_f   = a[W-2:NSIG];
  assign eb_f   = b[W-2:NSIG];
  assign fa     = a[NSIG-1:0];
  assign fb     = b[NSIG-1:0];
  assign a_nan  = (&ea_f) & (|fa);
  assign b_nan  = (&eb_f) & (|fb);
  assign a_snan = a_nan & ~fa[NSIG-1];
  assign b_snan = b_nan & ~fb[NSIG-1];
  assign a_inf  = (&ea_f) & ~(|fa);
  assign b_inf  = (&eb_f) & ~(|fb);
  assign a_zero = ~(|ea_f) & ~(|fa);
  assign b_zero = ~(|eb_f) & ~(|fb);
  assign a_sub  = ~(|ea_f) & (|fa);
  assign b_sub  = ~(|eb_f) & (|fb);
  assign s_sign = a[W-1] ^ b[W-1];

  logic         spec_hit;
  logic [W-1:0] spec_p;
  logic [5:0]   spec_flags;
  logic [3:0]   spec_exc;

  // A quieted sNaN is still reported as SNAN so the consumer can see the
  // result originated from a signalling operand.
  always_comb begin
    spec_hit   = 1'b1;
    spec_p     = '0;
    spec_flags = '0;
    spec_exc   = '0;
    if (a_snan) begin
      spec_p             = a | W'(1 << (NSIG - 1));
      spec_flags[F_SNAN] = 1'b1;
      spec_exc           = 4'b1000;
    end else if (b_snan) begin
      spec_p             = b | W'(1 << (NSIG - 1));
      spec_flags[F_SNAN] = 1'b1;
      spec_exc           = 4'b1000;
    end else if (a_nan) begin
      spec_p             = a;
      spec_flags[F_QNAN] = 1'b1;
    end else if (b_nan) begin
      spec_p             = b;
      spec_flags[F_QNAN] = 1'b1;
    end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
      spec_p             = {s_sign, {NEXP{1'b1}}, NSIG'(1 << (NSIG - 1))};
      spec_flags[F_QNAN] = 1'b1;
      spec_exc           = 4'b1000;
    end else if (a_inf | b_inf) begin
      spec_p             = {s_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      spec_flags[F_INF]  = 1'b1;
    end else if (a_zero | b_zero) begin
      spec_p             = {s_sign, {(W-1){1'b0}}};
      spec_flags[F_ZERO] = 1'b1;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // MSB-first shift-add: the partial product never exceeds the final one,
  // so PW bits suffice without a wider accumulator.
  logic [RADIX_BITS-1:0] digit;
  logic [PW-1:0]         acc_next;
  assign digit    = mplier[MW-1 -: RADIX_BITS];
  assign acc_next = {acc[PW-RADIX_BITS-1:0], {RADIX_BITS{1'b0}}} + PW'(sig_a) * PW'(digit);

  // rounding datapath, evaluated in RND
  logic [PW-1:0] mnorm, mshift, lost_mask;
  logic [EW-1:0] e_pre, e_tmp, e_fin, sh, sh_c;
  logic [SW-1:0] sig_t;
  logic [SW:0]   sum;
  logic [NSIG-1:0] frac;
  logic tiny, guard, sticky, inexact, inc, ovf, to_inf;
  logic [W-1:0]  rnd_p;
  logic [5:0]    rnd_flags;
  logic [3:0]    rnd_exc;

  always_comb begin
    mnorm     = acc[PW-1] ? acc : {acc[PW-2:0], 1'b0};
    e_pre     = exp_a + exp_b - EW'(BIAS) + EW'(acc[PW-1]);
    tiny      = e_pre[EW-1] | (e_pre == '0);
    sh        = EW'(1) - e_pre;
    sh_c      = (sh >= EW'(PW)) ? EW'(PW) : sh;
    lost_mask = ~({PW{1'b1}} << sh_c);
    mshift    = tiny ? (mnorm >> sh_c) : mnorm;
    sig_t     = mshift[PW-1 -: SW];
    guard     = mshift[SW-1];
    sticky    = (|mshift[SW-2:0]) | (tiny & (|(mnorm & lost_mask)));
    inexact   = guard | sticky;
    case (rnd_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign_q & inexact;
      3'b011:  inc = ~sign_q & inexact;
      3'b100:  inc = guard;
      default: inc = guard & (sticky | sig_t[0]);
    endcase
    case (rnd_q)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = sign_q;
      3'b011:  to_inf = ~sign_q;
      default: to_inf = 1'b1;
    endcase
    sum   = {1'b0, sig_t} + (SW+1)'(inc);
    e_tmp = tiny ? EW'(1) : e_pre;
    // A subnormal that rounds up into the hidden bit lands on the minimum
    // normal exponent; without the hidden bit the field stays zero.
    if (sum[SW]) begin
      e_fin = e_tmp + EW'(1);
      frac  = '0;
    end else begin
      e_fin = sum[NSIG] ? e_tmp : '0;
      frac  = sum[NSIG-1:0];
    end
    ovf       = (e_fin >= EW'(EMAXF));
    rnd_flags = '0;
    if (ovf) begin
      rnd_exc = 4'b0101;
      if (to_inf) begin
        rnd_p            = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
        rnd_flags[F_INF] = 1'b1;
      end else begin
        rnd_p             = {sign_q, NEXP'(EMAXF - 1), {NSIG{1'b1}}};
        rnd_flags[F_NORM] = 1'b1;
      end
    end else begin
      rnd_exc = {2'b00, tiny & inexact, inexact};
      rnd_p   = {sign_q, e_fin[NEXP-1:0], frac};
      if (e_fin == '0) begin
        if (frac == '0) rnd_flags[F_ZERO] = 1'b1;
        else            rnd_flags[F_SUB]  = 1'b1;
      end else begin
        rnd_flags[F_NORM] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      pFlags    <= '0;
      exc       <= '0;
      rnd_q     <= '0;
      sign_q    <= 1'b0;
      sig_a     <= '0;
      mplier    <= '0;
      exp_a     <= '0;
      exp_b     <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            rnd_q    <= rnd;
            sign_q   <= s_sign;
            sig_a    <= {~a_sub, fa};
            mplier   <= MW'({~b_sub, fb});
            exp_a    <= a_sub ? EW'(1) : EW'(ea_f);
            exp_b    <= b_sub ? EW'(1) : EW'(eb_f);
            acc      <= '0;
            cnt      <= CW'(NITER - 1);
            if (spec_hit) begin
              p         <= spec_p;
              pFlags    <= spec_flags;
              exc       <= spec_exc;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= (a_sub | b_sub) ? NORM : MUL;
            end
          end
        end
        NORM: begin
          // leave on the shift that sets the last missing hidden bit
          if (!sig_a[NSIG]) begin
            sig_a <= {sig_a[SW-2:0], 1'b0};
            exp_a <= exp_a - EW'(1);
            if (sig_a[NSIG-1] && mplier[NSIG]) state <= MUL;
          end else begin
            mplier <= {mplier[MW-2:0], 1'b0};
            exp_b  <= exp_b - EW'(1);
            if (mplier[NSIG-1]) state <= MUL;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mplier <= mplier << RADIX_BITS;
          if (cnt == '0) state <= RND;
          else           cnt   <= cnt - CW'(1);
        end
        RND: begin
          p         <= rnd_p;
          pFlags    <= rnd_flags;
          exc       <= rnd_exc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed vector bench for fp_mul_seq in half precision
// (NEXP=5, NSIG=10, RADIX_BITS=4, so NITER=3 and normal latency is 5).
`timescale 1ns/1ps
module tb_fp_mul_seq;
  localparam int NEXP = 5;
  localparam int NSIG = 10;
  localparam int RADIX_BITS = 4;
  localparam int W = NEXP + NSIG + 1;

  localparam logic [5:0] C_SNAN = 6'b100000;
  localparam logic [5:0] C_QNAN = 6'b010000;
  localparam logic [5:0] C_INF  = 6'b001000;
  localparam logic [5:0] C_ZERO = 6'b000100;
  localparam logic [5:0] C_SUB  = 6'b000010;
  localparam logic [5:0] C_NORM = 6'b000001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   rnd = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] p;
  logic [5:0]   pFlags;
  logic [3:0]   exc;

  int napplied = 0;
  int nmiss = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rnd;
    logic [15:0] p;
    logic [5:0]  fl;
    logic [3:0]  exc;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fp_mul_seq #(.NEXP(NEXP), .NSIG(NSIG), .RADIX_BITS(RADIX_BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .pFlags(pFlags), .exc(exc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    napplied++;
    if (act !== req) begin
      nmiss++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] vr,
                              input logic [15:0] vp, input logic [5:0] vf, input logic [3:0] ve,
                              input int vl);
    vec_t v;
    v.a = va; v.b = vb; v.rnd = vr; v.p = vp; v.fl = vf; v.exc = ve; v.lat = vl;
    return v;
  endfunction

  // Presents one operand pair and returns the number of rising edges from
  // the accepting edge (counted as 1) to the first one that shows out_valid.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] vr,
                        output int lat);
    @(negedge clk);
    a = va; b = vb; rnd = vr; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    rnd = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;

    //            a        b        rnd   p        class   exc      lat
    vecs.push_back(mk(16'h3E00, 16'h3E00, 3'd0, 16'h4080, C_NORM, 4'b0000, 5));
    vecs.push_back(mk(16'h3C01, 16'h3C01, 3'd0, 16'h3C02, C_NORM, 4'b0001, 5));
    vecs.push_back(mk(16'h3C01, 16'h3C01, 3'd1, 16'h3C02, C_NORM, 4'b0001, 5));
    vecs.push_back(mk(16'h3C01, 16'h3C01, 3'd3, 16'h3C03, C_NORM, 4'b0001, 5));
    vecs.push_back(mk(16'h7BFF, 16'h7BFF, 3'd0, 16'h7C00, C_INF,  4'b0101, 5));
    vecs.push_back(mk(16'h7BFF, 16'h7BFF, 3'd1, 16'h7BFF, C_NORM, 4'b0101, 5));
    vecs.push_back(mk(16'h7BFF, 16'h7BFF, 3'd2, 16'h7BFF, C_NORM, 4'b0101, 5));
    vecs.push_back(mk(16'hFBFF, 16'h7BFF, 3'd3, 16'hFBFF, C_NORM, 4'b0101, 5));
    vecs.push_back(mk(16'hFBFF, 16'h7BFF, 3'd2, 16'hFC00, C_INF,  4'b0101, 5));
    vecs.push_back(mk(16'hFBFF, 16'h7BFF, 3'd4, 16'hFC00, C_INF,  4'b0101, 5));
    vecs.push_back(mk(16'h0001, 16'h3800, 3'd0, 16'h0000, C_ZERO, 4'b0011, 15));
    vecs.push_back(mk(16'h0001, 16'h3800, 3'd4, 16'h0001, C_SUB,  4'b0011, 15));
    vecs.push_back(mk(16'h0001, 16'h3800, 3'd3, 16'h0001, C_SUB,  4'b0011, 15));
    vecs.push_back(mk(16'h7C00, 16'h0000, 3'd0, 16'h7E00, C_QNAN, 4'b1000, 1));
    vecs.push_back(mk(16'h7D00, 16'h3C00, 3'd0, 16'h7F00, C_SNAN, 4'b1000, 1));
    vecs.push_back(mk(16'h7E00, 16'h7D00, 3'd0, 16'h7F00, C_SNAN, 4'b1000, 1));
    vecs.push_back(mk(16'h7D01, 16'hFD02, 3'd0, 16'h7F01, C_SNAN, 4'b1000, 1));
    vecs.push_back(mk(16'hFE05, 16'h3C00, 3'd0, 16'hFE05, C_QNAN, 4'b0000, 1));
    vecs.push_back(mk(16'h3C00, 16'h8000, 3'd0, 16'h8000, C_ZERO, 4'b0000, 1));
    vecs.push_back(mk(16'hFC00, 16'h4000, 3'd0, 16'hFC00, C_INF,  4'b0000, 1));
    vecs.push_back(mk(16'h3C03, 16'h3E00, 3'd0, 16'h3E04, C_NORM, 4'b0001, 5));
    vecs.push_back(mk(16'h3C03, 16'h3E00, 3'd4, 16'h3E05, C_NORM, 4'b0001, 5));
    vecs.push_back(mk(16'h3C03, 16'h3E00, 3'd7, 16'h3E04, C_NORM, 4'b0001, 5));
    vecs.push_back(mk(16'h03FF, 16'h3C01, 3'd0, 16'h0400, C_NORM, 4'b0011, 6));
    vecs.push_back(mk(16'h03FF, 16'h3C01, 3'd1, 16'h03FF, C_SUB,  4'b0011, 6));
    vecs.push_back(mk(16'h0200, 16'h0200, 3'd0, 16'h0000, C_ZERO, 4'b0011, 7));
    vecs.push_back(mk(16'h0200, 16'h0200, 3'd3, 16'h0001, C_SUB,  4'b0011, 7));
    vecs.push_back(mk(16'h8001, 16'h0001, 3'd2, 16'h8001, C_SUB,  4'b0011, 25));
    vecs.push_back(mk(16'h8001, 16'h0001, 3'd1, 16'h8000, C_ZERO, 4'b0011, 25));
    vecs.push_back(mk(16'h0001, 16'h0001, 3'd0, 16'h0000, C_ZERO, 4'b0011, 25));

    // reset state
    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset p", 32'(p), 32'd0);
    check("reset pFlags", 32'(pFlags), 32'd0);
    check("reset exc", 32'(exc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
      run_op(vecs[i].a, vecs[i].b, vecs[i].rnd, lat);
      check($sformatf("v%0d p", i), 32'(p), 32'(vecs[i].p));
      check($sformatf("v%0d pFlags", i), 32'(pFlags), 32'(vecs[i].fl));
      check($sformatf("v%0d exc", i), 32'(exc), 32'(vecs[i].exc));
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      release_out();
    end

    // backpressure: result held, no new operands accepted
    run_op(16'h3E00, 16'h3E00, 3'd0, lat);
    check("bp latency", 32'(lat), 32'd5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'h3C00;
      b = 16'h4000;
      check($sformatf("bp%0d p", k), 32'(p), 32'h4080);
      check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_out();
    check("bp in_ready after", 32'(in_ready), 32'd1);
    check("bp out_valid after", 32'(out_valid), 32'd0);

    // reset in the middle of MUL
    @(negedge clk);
    a = 16'h3E00; b = 16'h3E00; rnd = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst p", 32'(p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("rst no result", 32'(seen), 32'd0);

    run_op(16'h3C01, 16'h3C01, 3'd3, lat);
    check("post-rst p", 32'(p), 32'h3C03);
    check("post-rst pFlags", 32'(pFlags), 32'(C_NORM));
    check("post-rst exc", 32'(exc), 32'b0001);
    check("post-rst latency", 32'(lat), 32'd5);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", napplied, nmiss);
    $finish;
  end
endmodule
